// File: rtl/sym_pack.sv
// Repacks a 7-bit symbol stream LSB-first into 32-bit words with packet framing.
// A small word FIFO absorbs the two-word burst produced when a packet closes.
module sym_pack #(
   parameter int SYM_W      = 7,
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [SYM_W-1:0]  data_in,
   input  logic              sop_in,
   input  logic              eop_in,
   output logic              valid_out,
   output logic [WORD_W-1:0] data_out,
   output logic              sop_out,
   output logic              eop_out,
   output logic [5:0]        bits_out,
   output logic              err_out,
   output logic              ovf_out
);

   localparam int ACC_W = WORD_W + SYM_W - 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [5:0] WORD_BITS = 6'(WORD_W);
   localparam logic [5:0] SYM_BITS  = 6'(SYM_W);

   typedef enum logic {IDLE, IN_PKT} state_t;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic              sop;
      logic              eop;
      logic [5:0]        bits;
   } entry_t;

   function automatic entry_t mk(input logic [WORD_W-1:0] d, input logic s,
                                 input logic e, input logic [5:0] b);
      entry_t r;
      r.data = d;
      r.sop  = s;
      r.eop  = e;
      r.bits = b;
      return r;
   endfunction

   state_t           state, state_n;
   logic [ACC_W-1:0] acc, acc_n, base_acc, sum;
   logic [5:0]       fill, fill_n, base_fill, total;
   logic             first, first_n, first_c;
   logic             err_n, mark, ovf_n, deq;
   entry_t           ent [2];
   logic [1:0]       n_enq, acc_cnt;
   entry_t           mem [FIFO_DEPTH];
   logic [AW-1:0]    rd, wr, last_wr;
   logic [AW:0]      count;
   logic [AW+1:0]    avail;

   // Packing datapath: up to two words leave per accepted symbol.
   always_comb begin
      state_n   = state;
      acc_n     = acc;
      fill_n    = fill;
      first_n   = first;
      err_n     = 1'b0;
      mark      = 1'b0;
      n_enq     = '0;
      ent[0]    = '0;
      ent[1]    = '0;
      base_acc  = acc;
      base_fill = fill;
      first_c   = first;
      sum       = '0;
      total     = '0;
      if (valid_in) begin
         if (state == IDLE && !sop_in) begin
            err_n = 1'b1;
         end else begin
            if (sop_in) begin
               if (state == IN_PKT) begin
                  err_n = 1'b1;
                  if (fill != '0) begin
                     ent[0] = mk(acc[WORD_W-1:0], first, 1'b1, fill);
                     n_enq  = 2'd1;
                  end else begin
                     mark = 1'b1;
                  end
               end
               base_acc  = '0;
               base_fill = '0;
               first_c   = 1'b1;
            end
            sum   = base_acc | (ACC_W'(data_in) << base_fill);
            total = base_fill + SYM_BITS;
            if (eop_in) begin
               if (total <= WORD_BITS) begin
                  ent[n_enq[0]] = mk(sum[WORD_W-1:0], first_c, 1'b1, total);
                  n_enq = n_enq + 2'd1;
               end else begin
                  ent[n_enq[0]] = mk(sum[WORD_W-1:0], first_c, 1'b0, WORD_BITS);
                  n_enq = n_enq + 2'd1;
                  ent[n_enq[0]] = mk(WORD_W'(sum >> WORD_W), 1'b0, 1'b1, total - WORD_BITS);
                  n_enq = n_enq + 2'd1;
               end
               acc_n   = '0;
               fill_n  = '0;
               first_n = 1'b0;
               state_n = IDLE;
            end else if (total >= WORD_BITS) begin
               ent[n_enq[0]] = mk(sum[WORD_W-1:0], first_c, 1'b0, WORD_BITS);
               n_enq   = n_enq + 2'd1;
               acc_n   = sum >> WORD_W;
               fill_n  = total - WORD_BITS;
               first_n = 1'b0;
               state_n = IN_PKT;
            end else begin
               acc_n   = sum;
               fill_n  = total;
               first_n = first_c;
               state_n = IN_PKT;
            end
         end
      end
   end

   // The head is popped every cycle it exists, so a pop frees a slot for this cycle's writes.
   always_comb begin
      deq   = (count != '0);
      avail = (AW+2)'(FIFO_DEPTH) - (AW+2)'(count) + (AW+2)'(deq);
      ovf_n = 1'b0;
      acc_cnt = n_enq;
      if ((AW+2)'(n_enq) > avail) begin
         acc_cnt = avail[1:0];
         ovf_n   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         acc       <= '0;
         fill      <= '0;
         first     <= 1'b0;
         rd        <= '0;
         wr        <= '0;
         last_wr   <= '0;
         count     <= '0;
         valid_out <= 1'b0;
         data_out  <= '0;
         sop_out   <= 1'b0;
         eop_out   <= 1'b0;
         bits_out  <= '0;
         err_out   <= 1'b0;
         ovf_out   <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         fill      <= fill_n;
         first     <= first_n;
         err_out   <= err_n;
         valid_out <= deq;
         if (ovf_n) ovf_out <= 1'b1;
         if (deq) begin
            data_out <= mem[rd].data;
            sop_out  <= mem[rd].sop;
            // A word leaving on the same edge an empty abort closes its packet still carries eop.
            eop_out  <= mem[rd].eop | (mark && rd == last_wr);
            bits_out <= mem[rd].bits;
            rd       <= rd + AW'(1);
         end else begin
            data_out <= '0;
            sop_out  <= 1'b0;
            eop_out  <= 1'b0;
            bits_out <= '0;
         end
         wr <= wr + AW'(acc_cnt);
         if (acc_cnt != '0) last_wr <= wr + AW'(acc_cnt) - AW'(1);
         count <= count + (AW+1)'(acc_cnt) - (AW+1)'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if (mark && count != '0) mem[last_wr].eop <= 1'b1;
         for (int k = 0; k < 2; k++) begin
            if (2'(k) < acc_cnt) mem[wr + AW'(k)] <= ent[k];
         end
      end
   end

endmodule

// File: tb/tb_sym_pack.sv
// Scoreboarded bench for sym_pack: a bit-queue packet model predicts words, a monitor checks them.
module tb_sym_pack;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic [6:0]  data_in = '0;
   logic        sop_in = 1'b0;
   logic        eop_in = 1'b0;
   logic        valid_out;
   logic [31:0] data_out;
   logic        sop_out;
   logic        eop_out;
   logic [5:0]  bits_out;
   logic        err_out;
   logic        ovf_out;

   sym_pack dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
      .sop_in(sop_in), .eop_in(eop_in), .valid_out(valid_out),
      .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out),
      .bits_out(bits_out), .err_out(err_out), .ovf_out(ovf_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [5:0]  bits;
   } exp_t;

   exp_t        exp_q[$];
   bit          bitq[$];
   bit          m_open = 0;
   bit          m_first = 0;
   int          total = 0;
   int          bad = 0;
   int          words_seen = 0;
   logic [31:0] last_data = '0;
   logic [5:0]  last_bits = '0;
   logic        err_stim = 1'b0;
   logic        err_d = 1'b0;
   bit          armed = 0;
   exp_t        mon_e;

   always @(posedge clk) err_d <= err_stim;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Pop up to 32 bits from the packet bit stream into one expected word.
   task automatic emit(input bit last);
      exp_t e;
      int   n;
      n = (bitq.size() > 32) ? 32 : bitq.size();
      e.data = '0;
      for (int i = 0; i < n; i++) e.data[i] = bitq.pop_front();
      e.bits = 6'(n);
      e.sop  = m_first;
      e.eop  = last;
      m_first = 0;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit v, input logic [6:0] d, input bit s, input bit e);
      exp_t t;
      err_stim = 1'b0;
      if (v) begin
         if (!m_open && !s) begin
            err_stim = 1'b1;
         end else begin
            if (s) begin
               if (m_open) begin
                  err_stim = 1'b1;
                  if (bitq.size() > 0) emit(1);
                  else if (exp_q.size() > 0) begin
                     t = exp_q.pop_back();
                     t.eop = 1'b1;
                     exp_q.push_back(t);
                  end
               end
               bitq.delete();
               m_first = 1;
               m_open  = 1;
            end
            for (int i = 0; i < 7; i++) bitq.push_back(d[i]);
            if (e) begin
               while (bitq.size() > 0) emit(bitq.size() <= 32);
               m_open = 0;
            end else begin
               while (bitq.size() >= 32) emit(0);
            end
         end
      end
      valid_in = v;
      data_in  = d;
      sop_in   = s;
      eop_in   = e;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      sop_in   = 1'b0;
      eop_in   = 1'b0;
      err_stim = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 7'h00, 0, 0);
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("err_out", 64'(err_out), 64'(err_d));
         chk("ovf_out", 64'(ovf_out), 64'd0);
         if (valid_out !== 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected word", 64'(data_out), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               chk("word", 64'({data_out, sop_out, eop_out, bits_out}),
                   64'({mon_e.data, mon_e.sop, mon_e.eop, mon_e.bits}));
               words_seen++;
               last_data = data_out;
               last_bits = bits_out;
            end
         end
      end
   end

   initial begin
      int w0;
      int len;
      int waited;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b1;
      armed = 1;

      // single-symbol packet and its latency
      drive(1, 7'h55, 1, 1);
      @(negedge clk);
      chk("latency early", 64'(valid_out), 64'd0);
      @(negedge clk);
      chk("latency 2 cycles", 64'(valid_out), 64'd1);
      #1;
      idle(4);
      chk("t1 word", 64'({last_data, last_bits}), 64'({32'h0000_0055, 6'd7}));

      // five symbols spilling into a 3-bit tail
      w0 = words_seen;
      drive(1, 7'h01, 1, 0);
      drive(1, 7'h02, 0, 0);
      drive(1, 7'h03, 0, 0);
      drive(1, 7'h04, 0, 0);
      drive(1, 7'h7F, 0, 1);
      idle(5);
      chk("t2 count", 64'(words_seen - w0), 64'd2);
      chk("t2 tail", 64'({last_data, last_bits}), 64'({32'h0000_0007, 6'd3}));

      // 160 back-to-back all-ones symbols, exact word multiple
      w0 = words_seen;
      for (int i = 0; i < 160; i++) drive(1, 7'h7F, i == 0, i == 159);
      idle(8);
      chk("t3 count", 64'(words_seen - w0), 64'd35);
      chk("t3 last", 64'({last_data, last_bits}), 64'({32'hFFFF_FFFF, 6'd32}));

      // stray symbol while idle, then a normal packet
      w0 = words_seen;
      drive(1, 7'h11, 0, 0);
      idle(3);
      chk("t4 no word", 64'(words_seen - w0), 64'd0);
      drive(1, 7'h21, 1, 1);
      idle(5);
      chk("t4 word", 64'({last_data, last_bits}), 64'({32'h0000_0021, 6'd7}));

      // sop without eop aborts the open packet
      w0 = words_seen;
      drive(1, 7'h01, 1, 0);
      drive(1, 7'h02, 0, 0);
      drive(1, 7'h03, 1, 1);
      idle(5);
      chk("t5 count", 64'(words_seen - w0), 64'd2);
      chk("t5 last", 64'({last_data, last_bits}), 64'({32'h0000_0003, 6'd7}));

      // reset in the middle of an open packet
      drive(1, 7'h0A, 1, 0);
      drive(1, 7'h0B, 0, 0);
      drive(1, 7'h0C, 0, 0);
      bitq.delete();
      m_open   = 0;
      m_first  = 0;
      rst      = 1'b0;
      valid_in = 1'b1;
      data_in  = 7'h7F;
      sop_in   = 1'b1;
      eop_in   = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b1;
      valid_in = 1'b0;
      sop_in   = 1'b0;
      eop_in   = 1'b0;
      @(negedge clk);
      chk("reset outputs", 64'({valid_out, data_out, sop_out, eop_out, bits_out, err_out, ovf_out}), 64'd0);
      #1;
      w0 = words_seen;
      drive(1, 7'h05, 1, 0);
      drive(1, 7'h06, 0, 1);
      idle(5);
      chk("t6 count", 64'(words_seen - w0), 64'd1);
      chk("t6 word", 64'({last_data, last_bits}), 64'({32'h0000_0305, 6'd14}));

      // randomized packets with gaps, strays and aborts
      for (int p = 0; p < 60; p++) begin
         if ($urandom_range(0, 9) == 0) drive(1, 7'($urandom), 0, 1'($urandom));
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            drive(1, 7'($urandom), (i == 0) || ($urandom_range(0, 19) == 0), i == len - 1);
         end
      end

      waited = 0;
      while (exp_q.size() > 0 && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      #1;
      idle(2);
      chk("drain", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
